// File: rtl/adapter_pkg.sv
// Shared state encoding and buffer-direction helpers for the adapter BRAM sequencer.
package adapter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  function automatic logic has_in(input int unsigned c_type, input int unsigned c_is_inout);
    return (c_is_inout != 0) || (c_type == 0);
  endfunction

  function automatic logic has_out(input int unsigned c_type, input int unsigned c_is_inout);
    return (c_is_inout != 0) || (c_type == 1);
  endfunction

endpackage

// File: rtl/adapter_beat_cnt.sv
// Clearable beat counter shared by the fill and drain phases; flags the last legal beat index.
module adapter_beat_cnt #(
  parameter int unsigned C_DATA_DEPTH = 16,
  parameter int unsigned C_ADDR_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_inc,
  output logic [C_ADDR_WIDTH:0]   o_count,
  output logic                    o_terminal_c
);

  localparam int unsigned CW = C_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] TERM = CW'(C_DATA_DEPTH - 1);

  logic [CW-1:0] r_count;

  // Clear has priority so a phase hand-off never carries a stale count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count      = r_count;
  assign o_terminal_c = (r_count == TERM);

endmodule

// File: rtl/adapter_bram_seq.sv
// Ownership sequencer for one adapter BRAM buffer: fill -> compute -> drain,
// driving the mux selects and the accelerator start handshake.
module adapter_bram_seq
  import adapter_pkg::*;
#(
  parameter int unsigned C_DATA_DEPTH = 16,
  parameter int unsigned C_ADDR_WIDTH = 4,
  parameter int unsigned C_TYPE       = 0,
  parameter int unsigned C_IS_INOUT   = 0
) (
  input  logic                  ACC_CLK,
  input  logic                  ACC_RESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  input_en,
  input  logic                  input_we_any,
  input  logic                  input_last,
  input  logic                  output_en,
  input  logic                  output_last,
  output logic                  ap_start,
  input  logic                  ap_done,
  output logic                  CTRL_EN_INPUT_IF,
  output logic                  CTRL_EN_OUTPUT_IF,
  output logic                  busy,
  output logic                  done,
  output logic [C_ADDR_WIDTH:0] fill_count,
  output logic                  err_access,
  output logic [1:0]            state
);

  localparam int unsigned CW      = C_ADDR_WIDTH + 1;
  localparam logic        HAS_IN  = has_in(C_TYPE, C_IS_INOUT);
  localparam logic        HAS_OUT = has_out(C_TYPE, C_IS_INOUT);

  logic [1:0]    r_state;
  logic          r_ap_start;
  logic          r_en_in;
  logic          r_en_out;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_fill_count;
  logic          r_err;

  logic [1:0]    w_state_nxt;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_done_nxt;
  logic          w_fill_latch;
  logic          w_start_acc;
  logic          w_err_nxt;
  logic [CW-1:0] w_cnt;
  logic          w_term;
  logic          w_fill_beat;
  logic          w_drain_beat;

  assign w_fill_beat  = input_en & input_we_any;
  assign w_drain_beat = output_en;

  adapter_beat_cnt #(
    .C_DATA_DEPTH (C_DATA_DEPTH),
    .C_ADDR_WIDTH (C_ADDR_WIDTH)
  ) u_beat_cnt (
    .i_clk        (ACC_CLK),
    .i_rst        (ACC_RESET),
    .i_clr        (w_cnt_clr),
    .i_inc        (w_cnt_inc),
    .o_count      (w_cnt),
    .o_terminal_c (w_term)
  );

  // State register.
  always_ff @(posedge ACC_CLK) begin
    if (ACC_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter control and pulse decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_done_nxt   = 1'b0;
    w_fill_latch = 1'b0;
    w_start_acc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_start_acc = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = HAS_IN ? ST_FILL : ST_COMPUTE;
        end
      end
      ST_FILL: begin
        if (w_fill_beat) begin
          w_cnt_inc = 1'b1;
          if (input_last || w_term) begin
            w_fill_latch = 1'b1;
            w_state_nxt  = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        if (ap_done) begin
          w_cnt_clr = 1'b1;
          if (HAS_OUT) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_drain_beat) begin
          w_cnt_inc = 1'b1;
          if (output_last || w_term) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort cancels silently: no done pulse and the previous fill_count survives.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_clr    = 1'b1;
      w_cnt_inc    = 1'b0;
      w_done_nxt   = 1'b0;
      w_fill_latch = 1'b0;
    end
  end

  // A mover beat outside its own phase is a protocol violation, even on a start cycle.
  always_comb begin
    w_err_nxt = r_err;
    if (w_start_acc) begin
      w_err_nxt = 1'b0;
    end
    if ((w_fill_beat && (r_state != ST_FILL)) || (w_drain_beat && (r_state != ST_DRAIN))) begin
      w_err_nxt = 1'b1;
    end
  end

  // Outputs registered from the next state so they line up with the state register.
  always_ff @(posedge ACC_CLK) begin
    if (ACC_RESET) begin
      r_ap_start   <= 1'b0;
      r_en_in      <= 1'b0;
      r_en_out     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fill_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_ap_start <= (w_state_nxt == ST_COMPUTE);
      r_en_in    <= (w_state_nxt == ST_FILL);
      r_en_out   <= (w_state_nxt == ST_DRAIN);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      if (w_fill_latch) begin
        r_fill_count <= w_cnt + CW'(1);
      end
    end
  end

  assign state             = r_state;
  assign ap_start          = r_ap_start;
  assign CTRL_EN_INPUT_IF  = r_en_in;
  assign CTRL_EN_OUTPUT_IF = r_en_out;
  assign busy              = r_busy;
  assign done              = r_done;
  assign fill_count        = r_fill_count;
  assign err_access        = r_err;

endmodule

// File: tb/tb_adapter_bram_seq.sv
// Bench for adapter_bram_seq: three buffer flavours (input-only, inout, output-only)
// driven with randomized transactions and checked against spec-level expectations.
module tb_adapter_bram_seq;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] start_i, abort_i, in_en, in_we, in_last, out_en, out_last, ap_done_i;
  logic ap_start_o [3];
  logic en_in_o    [3];
  logic en_out_o   [3];
  logic busy_o     [3];
  logic done_o     [3];
  logic err_o      [3];
  logic [1:0] state_o [3];
  logic [4:0] fcnt_o  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc [3];

  always #5 clk = ~clk;

  // Instance 0: input-only, 1: inout, 2: output-only.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    adapter_bram_seq #(
      .C_DATA_DEPTH (16),
      .C_ADDR_WIDTH (4),
      .C_TYPE       ((g == 2) ? 1 : 0),
      .C_IS_INOUT   ((g == 1) ? 1 : 0)
    ) u_dut (
      .ACC_CLK           (clk),
      .ACC_RESET         (rst),
      .start             (start_i[g]),
      .abort             (abort_i[g]),
      .input_en          (in_en[g]),
      .input_we_any      (in_we[g]),
      .input_last        (in_last[g]),
      .output_en         (out_en[g]),
      .output_last       (out_last[g]),
      .ap_start          (ap_start_o[g]),
      .ap_done           (ap_done_i[g]),
      .CTRL_EN_INPUT_IF  (en_in_o[g]),
      .CTRL_EN_OUTPUT_IF (en_out_o[g]),
      .busy              (busy_o[g]),
      .done              (done_o[g]),
      .fill_count        (fcnt_o[g]),
      .err_access        (err_o[g]),
      .state             (state_o[g])
    );
  end

  // Expected visible outputs for a given state: {state, busy, ap_start, en_in, en_out, done}.
  function automatic logic [6:0] mk(input logic [1:0] st, input logic d);
    return {st, st != S_IDLE, st == S_COMP, st == S_FILL, st == S_DRAIN, d};
  endfunction

  function automatic logic [6:0] snap(input int i);
    return {state_o[i], busy_o[i], ap_start_o[i], en_in_o[i], en_out_o[i], done_o[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in(input int i);
    start_i[i] = 0; abort_i[i] = 0; in_en[i] = 0; in_we[i] = 0; in_last[i] = 0;
    out_en[i] = 0; out_last[i] = 0; ap_done_i[i] = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) clr_in(i);
    rst = 1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({snap(i), err_o[i], fcnt_o[i]} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset[%0d] got %b exp all zero", i, {snap(i), err_o[i], fcnt_o[i]});
      end
      exp_fc[i] = 0;
    end
    rst = 0;
    tick();
  endtask

  // One full transaction on instance i; every cycle is checked against the phase rules.
  task automatic run_txn(input int i, input int n_fill, input bit fill_last, input int cdelay,
                         input int n_drain, input bit drain_last);
    bit hin;
    bit hout;
    int beats;
    hin  = (i != 2);
    hout = (i != 0);
    clr_in(i);
    start_i[i] = 1;
    tick();
    start_i[i] = 0;
    n_tests++;
    if (snap(i) !== mk(hin ? S_FILL : S_COMP, 0) || err_o[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL txn_start[%0d] got %b/%b exp %b/0", i, snap(i), err_o[i], mk(hin ? S_FILL : S_COMP, 0));
    end
    if (hin) begin
      beats = 0;
      while (beats < n_fill) begin
        if ($urandom_range(0, 3) == 0) begin
          in_en[i]     = 1'($urandom_range(0, 1));
          in_we[i]     = in_en[i] ? 1'b0 : 1'($urandom_range(0, 1));
          in_last[i]   = 1'($urandom_range(0, 1));
          ap_done_i[i] = 1'($urandom_range(0, 1));
          tick();
          clr_in(i);
          n_tests++;
          if (snap(i) !== mk(S_FILL, 0)) begin
            n_fail++;
            $display("FAIL fill_gap[%0d] got %b exp %b", i, snap(i), mk(S_FILL, 0));
          end
        end else begin
          beats++;
          in_en[i]   = 1;
          in_we[i]   = 1;
          in_last[i] = (beats == n_fill) ? fill_last : 1'b0;
          tick();
          clr_in(i);
          if (beats < n_fill) begin
            n_tests++;
            if (snap(i) !== mk(S_FILL, 0)) begin
              n_fail++;
              $display("FAIL fill_beat%0d[%0d] got %b exp %b", beats, i, snap(i), mk(S_FILL, 0));
            end
          end else begin
            exp_fc[i] = n_fill;
            n_tests++;
            if (snap(i) !== mk(S_COMP, 0) || fcnt_o[i] !== 5'(n_fill)) begin
              n_fail++;
              $display("FAIL fill_end[%0d] got %b fc=%0d exp %b fc=%0d", i, snap(i), fcnt_o[i],
                       mk(S_COMP, 0), n_fill);
            end
          end
        end
      end
    end
    for (int c = 0; c < cdelay; c++) begin
      start_i[i] = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (snap(i) !== mk(S_COMP, 0)) begin
        n_fail++;
        $display("FAIL compute_hold[%0d] got %b exp %b", i, snap(i), mk(S_COMP, 0));
      end
    end
    ap_done_i[i] = 1;
    tick();
    clr_in(i);
    if (!hout) begin
      n_tests++;
      if (snap(i) !== mk(S_IDLE, 1)) begin
        n_fail++;
        $display("FAIL compute_done[%0d] got %b exp %b", i, snap(i), mk(S_IDLE, 1));
      end
    end else begin
      n_tests++;
      if (snap(i) !== mk(S_DRAIN, 0)) begin
        n_fail++;
        $display("FAIL drain_enter[%0d] got %b exp %b", i, snap(i), mk(S_DRAIN, 0));
      end
      beats = 0;
      while (beats < n_drain) begin
        if ($urandom_range(0, 3) == 0) begin
          out_last[i]  = 1'($urandom_range(0, 1));
          ap_done_i[i] = 1'($urandom_range(0, 1));
          tick();
          clr_in(i);
          n_tests++;
          if (snap(i) !== mk(S_DRAIN, 0)) begin
            n_fail++;
            $display("FAIL drain_gap[%0d] got %b exp %b", i, snap(i), mk(S_DRAIN, 0));
          end
        end else begin
          beats++;
          out_en[i]   = 1;
          out_last[i] = (beats == n_drain) ? drain_last : 1'b0;
          tick();
          clr_in(i);
          n_tests++;
          if (snap(i) !== mk((beats < n_drain) ? S_DRAIN : S_IDLE, beats == n_drain)) begin
            n_fail++;
            $display("FAIL drain_beat%0d[%0d] got %b exp %b", beats, i, snap(i),
                     mk((beats < n_drain) ? S_DRAIN : S_IDLE, beats == n_drain));
          end
        end
      end
    end
    tick();
    n_tests++;
    if (snap(i) !== mk(S_IDLE, 0) || err_o[i] !== 1'b0 || fcnt_o[i] !== 5'(exp_fc[i])) begin
      n_fail++;
      $display("FAIL txn_end[%0d] got %b err=%b fc=%0d exp %b err=0 fc=%0d", i, snap(i), err_o[i],
               fcnt_o[i], mk(S_IDLE, 0), exp_fc[i]);
    end
  endtask

  task automatic rand_txn(input int i);
    int nf;
    int nd;
    nf = $urandom_range(1, 16);
    nd = $urandom_range(1, 16);
    run_txn(i, nf, (nf < 16) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 6),
            nd, (nd < 16) ? 1'b1 : 1'($urandom_range(0, 1)));
  endtask

  task automatic test_fill_path();
    run_txn(0, 16, 0, 3, 0, 0);
    run_txn(0, $urandom_range(1, 15), 1, $urandom_range(0, 6), 0, 0);
    run_txn(0, 16, 1, 0, 0, 0);
  endtask

  task automatic test_inout_path();
    run_txn(1, 5, 1, 9, 3, 1);
    run_txn(1, 16, 0, 2, 16, 0);
    rand_txn(1);
  endtask

  task automatic test_output_path();
    run_txn(2, 0, 0, 0, 16, 0);
    run_txn(2, 0, 0, 4, 1, 1);
    rand_txn(2);
  endtask

  task automatic test_abort();
    // Abort in COMPUTE on the inout buffer, then a stray ap_done.
    start_i[1] = 1; tick(); start_i[1] = 0;
    in_en[1] = 1; in_we[1] = 1; tick();
    in_last[1] = 1; tick(); clr_in(1);
    exp_fc[1] = 2;
    abort_i[1] = 1; tick(); abort_i[1] = 0;
    n_tests++;
    if (snap(1) !== mk(S_IDLE, 0) || fcnt_o[1] !== 5'd2) begin
      n_fail++;
      $display("FAIL abort_compute got %b fc=%0d exp %b fc=2", snap(1), fcnt_o[1], mk(S_IDLE, 0));
    end
    ap_done_i[1] = 1; tick(); ap_done_i[1] = 0;
    n_tests++;
    if (snap(1) !== mk(S_IDLE, 0)) begin
      n_fail++;
      $display("FAIL abort_stray_done got %b exp %b", snap(1), mk(S_IDLE, 0));
    end
    // Abort mid-FILL keeps the previous fill_count.
    start_i[0] = 1; tick(); start_i[0] = 0;
    in_en[0] = 1; in_we[0] = 1; tick(); tick(); tick(); clr_in(0);
    abort_i[0] = 1; tick(); abort_i[0] = 0;
    n_tests++;
    if (snap(0) !== mk(S_IDLE, 0) || fcnt_o[0] !== 5'(exp_fc[0])) begin
      n_fail++;
      $display("FAIL abort_fill got %b fc=%0d exp %b fc=%0d", snap(0), fcnt_o[0], mk(S_IDLE, 0), exp_fc[0]);
    end
    // Abort mid-DRAIN on the output buffer.
    start_i[2] = 1; tick(); start_i[2] = 0;
    ap_done_i[2] = 1; tick(); ap_done_i[2] = 0;
    out_en[2] = 1; tick(); tick(); clr_in(2);
    abort_i[2] = 1; tick(); abort_i[2] = 0;
    n_tests++;
    if (snap(2) !== mk(S_IDLE, 0)) begin
      n_fail++;
      $display("FAIL abort_drain got %b exp %b", snap(2), mk(S_IDLE, 0));
    end
    tick();
    n_tests++;
    if (done_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done got %b exp 0", done_o[2]);
    end
    run_txn(2, 0, 0, 1, 16, 0);
  endtask

  task automatic test_access_err();
    in_en[0] = 1; in_we[0] = 1; tick(); clr_in(0);
    n_tests++;
    if (err_o[0] !== 1'b1 || state_o[0] !== S_IDLE) begin
      n_fail++;
      $display("FAIL err_fill_idle got err=%b st=%0d exp err=1 st=0", err_o[0], state_o[0]);
    end
    tick(); tick(); tick();
    n_tests++;
    if (err_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got %b exp 1", err_o[0]);
    end
    start_i[0] = 1; tick(); start_i[0] = 0;
    n_tests++;
    if (err_o[0] !== 1'b0 || snap(0) !== mk(S_FILL, 0)) begin
      n_fail++;
      $display("FAIL err_clear_on_start got err=%b %b exp err=0 %b", err_o[0], snap(0), mk(S_FILL, 0));
    end
    abort_i[0] = 1; tick(); abort_i[0] = 0;
    // Drain beat while idle on inout, then start+abort together must not clear it.
    out_en[1] = 1; tick(); clr_in(1);
    start_i[1] = 1; abort_i[1] = 1; tick(); clr_in(1);
    n_tests++;
    if (snap(1) !== mk(S_IDLE, 0) || err_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_abort_same got %b err=%b exp %b err=1", snap(1), err_o[1], mk(S_IDLE, 0));
    end
    // Fill beat during COMPUTE on the output buffer.
    start_i[2] = 1; tick(); start_i[2] = 0;
    in_en[2] = 1; in_we[2] = 1; tick(); clr_in(2);
    n_tests++;
    if (err_o[2] !== 1'b1 || snap(2) !== mk(S_COMP, 0)) begin
      n_fail++;
      $display("FAIL err_fill_compute got err=%b %b exp err=1 %b", err_o[2], snap(2), mk(S_COMP, 0));
    end
    abort_i[2] = 1; tick(); abort_i[2] = 0;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) rand_txn(i);
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 3; i++) start_i[i] = 1;
    tick();
    for (int i = 0; i < 3; i++) start_i[i] = 0;
    for (int b = 0; b < 7; b++) begin
      in_en[0] = 1; in_we[0] = 1; tick();
    end
    clr_in(0);
    n_tests++;
    if (snap(0) !== mk(S_FILL, 0) || fcnt_o[0] !== 5'(exp_fc[0])) begin
      n_fail++;
      $display("FAIL pre_reset got %b fc=%0d exp %b fc=%0d", snap(0), fcnt_o[0], mk(S_FILL, 0), exp_fc[0]);
    end
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({snap(i), err_o[i], fcnt_o[i]} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got %b exp all zero", i, {snap(i), err_o[i], fcnt_o[i]});
      end
      exp_fc[i] = 0;
    end
    tick();
    run_txn(0, 4, 1, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill_path();
    test_inout_path();
    test_output_path();
    test_abort();
    test_access_err();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adapter_bram_seq.md
Name: adapter_bram_seq

Overview:
Ownership sequencer for one adapter BRAM buffer. It drives the CTRL_EN_INPUT_IF and CTRL_EN_OUTPUT_IF selects of the buffer's muxes and sequences each transaction as fill, then compute, then drain. Fill is the input mover writing the buffer. Compute is the accelerator owning the buffer through the ap_start/ap_done handshake. Drain is the output mover reading results back. It sits between the host control block and adapter_bram, one instance per buffer, and uses the same C_TYPE and C_IS_INOUT settings as that buffer.

Parameters:
C_DATA_DEPTH, 16, buffer depth in words; maximum beats per fill or drain phase
C_ADDR_WIDTH, 4, address width; the beat counter is C_ADDR_WIDTH+1 bits
C_TYPE, 0, 0 = input buffer, 1 = output buffer (ignored when C_IS_INOUT = 1)
C_IS_INOUT, 0, 1 = buffer is both filled and drained

Ports:
ACC_CLK  in  1  clock
ACC_RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a transaction
abort  in  1  one-cycle request to cancel the transaction and return to IDLE
input_en  in  1  input mover BRAM enable (monitored)
input_we_any  in  1  OR-reduction of the input mover's write enables
input_last  in  1  marks the final fill beat
output_en  in  1  output mover BRAM enable (monitored)
output_last  in  1  marks the final drain beat
ap_start  out  1  accelerator start
ap_done  in  1  one-cycle accelerator completion pulse
CTRL_EN_INPUT_IF  out  1  input mover owns the buffer
CTRL_EN_OUTPUT_IF  out  1  output mover owns the buffer
busy  out  1  state is not IDLE
done  out  1  one-cycle transaction-complete pulse
fill_count  out  C_ADDR_WIDTH+1  number of words written in the last fill phase
err_access  out  1  sticky flag: mover beat seen without ownership
state  out  2  current state, for debug

Behaviour:
- Reset behaviour: ACC_CLK and ACC_RESET are the only clock and reset. ACC_RESET is synchronous and active-high.
- Reset values: state = IDLE; every output = 0; beat counter = 0.
- Derived flags:
  - HAS_IN = C_IS_INOUT or (C_TYPE == 0).
  - HAS_OUT = C_IS_INOUT or (C_TYPE == 1).
- State encoding: IDLE = 0, FILL = 1, COMPUTE = 2, DRAIN = 3.
- Beat definitions:
  - Fill beat = input_en & input_we_any.
  - Drain beat = output_en.
- Registered outputs, decoded from the current state:
  - CTRL_EN_INPUT_IF = (state == FILL).
  - CTRL_EN_OUTPUT_IF = (state == DRAIN).
  - ap_start = (state == COMPUTE).
  - Both enables are 0 in IDLE and COMPUTE, so the accelerator port owns the muxed BRAM port.
- IDLE:
  - On start, clear the counter and err_access.
  - Next state is FILL if HAS_IN, otherwise COMPUTE.
- FILL:
  - The counter increments on each fill beat.
  - The last beat is a beat with input_last, or a beat with counter == C_DATA_DEPTH-1.
  - On the last beat, latch fill_count = counter+1 and go to COMPUTE on the next cycle.
  - Ownership changes one cycle after the last beat; there is no bubble beyond that cycle.
- COMPUTE:
  - ap_start is held high until ap_done is sampled high.
  - On ap_done, clear the counter.
  - If HAS_OUT, go to DRAIN. Otherwise go to IDLE and pulse done.
  - ap_done seen in any other state is ignored.
- DRAIN:
  - The counter increments on each drain beat.
  - The last beat is a beat with output_last, or a beat with counter == C_DATA_DEPTH-1.
  - On the last beat, go to IDLE and pulse done in the same cycle the state becomes IDLE.
- err_access:
  - Set on a fill beat when state != FILL.
  - Set on a drain beat when state != DRAIN.
  - Sticky; cleared only by reset or by an accepted start.
- start while busy is ignored.
- abort in any non-IDLE state: next state IDLE, ap_start and enables drop next cycle, counter cleared, done is not pulsed, fill_count is kept.
- abort and start in the same cycle in IDLE: abort wins and start is dropped.
- Counter width C_ADDR_WIDTH+1 means it never wraps, because the phase ends at C_DATA_DEPTH beats.
- ACC_RESET asserted mid-transaction overrides everything and returns all outputs to their reset values.

Decomposition:
- Shared package adapter_pkg holds:
  - state localparams ST_IDLE, ST_FILL, ST_COMPUTE, ST_DRAIN;
  - function has_in(C_TYPE, C_IS_INOUT);
  - function has_out(C_TYPE, C_IS_INOUT).
- One natural sub-module: adapter_beat_cnt. It is a clearable beat counter with a terminal flag at C_DATA_DEPTH-1, shared by the FILL and DRAIN phases.

Test Plan:
- Fill path, C_TYPE=0, C_IS_INOUT=0: start, then 16 fill beats with no last.
  - CTRL_EN_INPUT_IF is 1 during the beats.
  - fill_count = 16.
  - ap_start rises the cycle after beat 16.
  - ap_done brings state to IDLE with one done pulse.
  - DRAIN is never entered.
- Inout path, C_IS_INOUT=1: start, 5 fill beats with input_last on the 5th, ap_done after 10 cycles, then 3 drain beats with output_last on the 3rd.
  - fill_count = 5.
  - CTRL_EN_OUTPUT_IF is 1 for the drain window only.
  - done pulses exactly once.
- Output-only path, C_TYPE=1: start.
  - ap_start is high on the next cycle; FILL is skipped.
  - After ap_done, DRAIN is entered.
  - 16 drain beats return state to IDLE.
- Abort during COMPUTE: abort with ap_start high.
  - Next cycle: ap_start = 0, state = IDLE, no done pulse.
  - A later ap_done is ignored.
- Access errors: a fill beat in IDLE sets err_access = 1 and it stays set; the next start clears it. In a separate case, start and abort in the same cycle leave state = IDLE.
- Reset mid-FILL after 7 beats: ACC_RESET drives all outputs to 0 and fill_count to 0 on the next cycle.
